// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: two requesters share one add/sub datapath.
// A round-robin arbiter in IDLE grants one request. EXEC computes the
// result from the registered operands. HOLD presents the result until the
// consumer accepts it.
//
// Handshake rules:
//   - A request transfers on a cycle where reqN_valid and reqN_ready are
//     both 1.
//   - A response transfers on a cycle where resp_valid and resp_ready are
//     both 1.
//   - reqN_ready is combinational. It can be 1 only in IDLE, and only while
//     reset is released.
//   - The response outputs are registered. They stay stable while
//     resp_valid=1 and resp_ready=0.
module add_sub_arbiter #(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0_valid,
  input  logic                   req0_op,
  input  logic [WORD_LENGTH-1:0] req0_a0,
  input  logic [WORD_LENGTH-1:0] req0_a1,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic                   req1_op,
  input  logic [WORD_LENGTH-1:0] req1_a0,
  input  logic [WORD_LENGTH-1:0] req1_a1,
  output logic                   req1_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [WORD_LENGTH-1:0] resp_data,
  output logic                   resp_ovf,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int MSB = WORD_LENGTH - 1;

  state_t                 state_q;
  logic                   prio_q;      // preferred requester when both are valid
  logic                   op_q;
  logic                   id_q;
  logic [WORD_LENGTH-1:0] a0_q;
  logic [WORD_LENGTH-1:0] a1_q;
  logic                   resp_valid_q;
  logic                   resp_id_q;
  logic [WORD_LENGTH-1:0] resp_data_q;
  logic                   resp_ovf_q;

  logic                   grant_en;
  logic                   grant_id;
  logic                   grant_op;
  logic [WORD_LENGTH-1:0] grant_a0;
  logic [WORD_LENGTH-1:0] grant_a1;
  logic [WORD_LENGTH-1:0] resp_data_d;
  logic                   resp_ovf_d;

  // Round-robin pick. A lone valid request wins regardless of priority.
  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = prio_q;
    end else begin
      grant_id = req1_valid;
    end
    grant_en   = reset && (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = grant_en && !grant_id;
    req1_ready = grant_en && grant_id;
    grant_op   = grant_id ? req1_op : req0_op;
    grant_a0   = grant_id ? req1_a0 : req0_a0;
    grant_a1   = grant_id ? req1_a1 : req0_a1;
  end

  // Shared datapath. The carry or borrow is dropped, and signed overflow is
  // reported alongside the result.
  always_comb begin
    resp_data_d = op_q ? (a0_q - a1_q) : (a0_q + a1_q);
    if (op_q) begin
      resp_ovf_d = (a0_q[MSB] != a1_q[MSB]) && (resp_data_d[MSB] != a0_q[MSB]);
    end else begin
      resp_ovf_d = (a0_q[MSB] == a1_q[MSB]) && (resp_data_d[MSB] != a0_q[MSB]);
    end
  end

  // Control FSM with registered operands and response. Reset discards any
  // operation in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      a0_q         <= '0;
      a1_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            op_q    <= grant_op;
            a0_q    <= grant_a0;
            a1_q    <= grant_a1;
            id_q    <= grant_id;
            prio_q  <= ~grant_id;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= resp_data_d;
          resp_ovf_q   <= resp_ovf_d;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_ovf    = resp_ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/add_sub_arbiter.md
ADD_SUB_ARBITER -- requirements
Module: add_sub_arbiter

Interface
REQ-001 Parameter: WORD_LENGTH, default 32, operand/result width in bits.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-low; sampled on rising clk edge.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_op  in  1  requester 0 operation: 0 = A0+A1, 1 = A0-A1.
REQ-007 req0_a0, req0_a1  in  WORD_LENGTH  requester 0 operands.
REQ-008 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-009 req1_valid, req1_op, req1_a0, req1_a1, req1_ready  same widths/meaning as REQ-005..008, for requester 1.
REQ-010 resp_valid  out  1  result available.
REQ-011 resp_ready  in  1  consumer takes result.
REQ-012 resp_id  out  1  requester that owns the result (0/1).
REQ-013 resp_data  out  WORD_LENGTH  result, modulo 2^WORD_LENGTH.
REQ-014 resp_ovf  out  1  two's-complement signed overflow of the result.

Function
REQ-015 The block SHALL own one shared add/sub datapath and serve requesters one at a time through FSM states IDLE, EXEC, HOLD.
REQ-016 IDLE: if no reqN_valid, stay; otherwise grant exactly one requester, assert its reqN_ready combinationally in that cycle, register op/a0/a1/id, go to EXEC.
REQ-017 reqN_ready SHALL be 1 only in IDLE, only for the granted requester, and only when its reqN_valid=1; never both readies high.
REQ-018 Arbitration SHALL be round-robin: a priority bit selects the preferred requester; if only one is valid it wins regardless of priority.
REQ-019 After each grant the priority bit SHALL point to the non-granted requester.
REQ-020 EXEC: compute on registered operands, register resp_data, resp_ovf, resp_id, set resp_valid=1, go to HOLD (one cycle, unconditional).
REQ-021 HOLD: resp_valid, resp_data, resp_id, resp_ovf SHALL remain stable while resp_ready=0; on resp_ready=1 clear resp_valid and go to IDLE.
REQ-022 No new grant SHALL occur in HOLD or EXEC; earliest next grant is the cycle after the resp_ready handshake.
REQ-023 Latency: grant at edge N -> resp_valid=1 after edge N+1; minimum 3 cycles per operation.
REQ-024 Add overflow: a0[MSB]==a1[MSB] and resp_data[MSB]!=a0[MSB].
REQ-025 Sub overflow: a0[MSB]!=a1[MSB] and resp_data[MSB]!=a0[MSB].
REQ-026 Wrap-around SHALL be silent (carry/borrow discarded); resp_ovf is informational only.
REQ-027 Requesters SHALL hold valid/op/operands stable until ready; a valid dropped before ready is not served and causes no error.
REQ-028 Simultaneous valid on both: winner per priority bit; loser waits in IDLE for the next grant.

Reset
REQ-029 On reset=0 at a clk edge: state=IDLE, resp_valid=0, resp_data=0, resp_id=0, resp_ovf=0, priority=requester 0, internal operand registers=0.
REQ-030 Reset mid-operation (EXEC or HOLD) SHALL discard the operation; no resp_valid for it after reset.
REQ-031 While reset=0, req0_ready and req1_ready SHALL be 0.

Verification
REQ-032 req0 only, op=0, a0=0x00000005, a1=0x00000003, resp_ready=1 -> req0_ready one cycle, resp_valid two edges later, resp_data=0x00000008, id=0, ovf=0.
REQ-033 req1 only, op=1, a0=0x00000003, a1=0x00000005 -> resp_data=0xFFFFFFFE, id=1, ovf=0.
REQ-034 Both valid continuously after reset, resp_ready=1 -> grants alternate 0,1,0,1; never both ready in one cycle.
REQ-035 op=0, a0=0x7FFFFFFF, a1=0x00000001 -> resp_data=0x80000000, ovf=1; op=1, a0=0x80000000, a1=0x00000001 -> 0x7FFFFFFF, ovf=1.
REQ-036 resp_ready=0 for 5 cycles in HOLD -> resp outputs stable, no readies; resp_ready=1 -> resp_valid=0 next cycle, next grant following cycle.
REQ-037 reset=0 asserted in HOLD -> next cycle resp_valid=0, all outputs zero, priority back to requester 0.
